// File: rtl/rr_arb_4.sv
// rr_arb_4: four-channel round-robin arbiter feeding a single registered output stage.
module rr_arb_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);
  logic [1:0]       r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_sel;
  logic             w_load_en;
  logic             w_any;
  logic             w_fire;
  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_grant;
  logic [WIDTH-1:0] w_data;
  assign w_load_en = !r_out_valid || out_ready;
  assign w_any     = |in_valid;
  // bit k of w_rot is the request of channel (ptr + k) mod 4
  assign w_rot = r_ptr == 2'd0 ? in_valid :
                 r_ptr == 2'd1 ? {in_valid[0], in_valid[3:1]} :
                 r_ptr == 2'd2 ? {in_valid[1:0], in_valid[3:2]} :
                                 {in_valid[2:0], in_valid[3]};
  assign w_off   = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign w_grant = r_ptr + w_off;
  // rst_n gates in_ready so nothing is accepted while reset is held
  assign w_fire   = rst_n && w_load_en && w_any;
  assign in_ready = w_fire ? (4'b0001 << w_grant) : 4'b0000;
  assign w_data = w_grant == 2'd0 ? in_data0 :
                  w_grant == 2'd1 ? in_data1 :
                  w_grant == 2'd2 ? in_data2 : in_data3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 2'd0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_sel   <= w_grant;
        r_ptr       <= w_grant + 2'd1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
endmodule

// File: tb/tb_rr_arb_4.sv
// tb_rr_arb_4: directed and random checks of rr_arb_4 against a channel-scan reference model.
module tb_rr_arb_4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_valid = 4'b0000;
  logic [3:0] tb_d [4];
  logic [3:0] in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;
  int m_ov = 0;
  int m_od = 0;
  int m_os = 0;

  rr_arb_4 #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data0(tb_d[0]), .in_data1(tb_d[1]), .in_data2(tb_d[2]), .in_data3(tb_d[3]),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_grant();
    for (int k = 0; k < 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic int m_ready();
    int g;
    g = m_grant();
    if (!rst_n || !(m_ov == 0 || out_ready) || g < 0) return 0;
    return 1 << g;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_ov = 0; m_od = 0; m_os = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), m_ov);
    chk({tag, ".out_data"}, int'(out_data), m_od);
    chk({tag, ".out_sel"}, int'(out_sel), m_os);
  endtask

  // called just after a falling edge with inputs set; returns just after the next falling edge
  task automatic cycle(input string tag);
    int g;
    #1;
    chk({tag, ".in_ready"}, int'(in_ready), m_ready());
    chk_outs(tag);
    @(posedge clk);
    g = m_grant();
    if (!rst_n) m_reset();
    else if (m_ov == 0 || out_ready) begin
      if (g >= 0) begin
        m_ov = 1; m_od = int'(tb_d[g]); m_os = g; m_ptr = (g + 1) % 4;
      end else m_ov = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_outs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tb_d[i] = 4'(i + 1);
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("reset_hold");
    rst_n = 1'b1;

    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fair.in_ready", int'(in_ready), 1 << (i % 4));
      cycle("fair");
      chk("fair.sel", int'(out_sel), i % 4);
      chk("fair.data", int'(out_data), (i % 4) + 1);
      chk("fair.valid", int'(out_valid), 1);
    end

    do_reset();
    in_valid = 4'b0100; tb_d[2] = 4'hA; out_ready = 1'b1;
    #1;
    chk("single.in_ready", int'(in_ready), 4'b0100);
    cycle("single");
    chk("single.data", int'(out_data), 4'hA);
    chk("single.sel", int'(out_sel), 2);
    in_valid = 4'b0011;
    #1;
    chk("wrap.in_ready0", int'(in_ready), 4'b0001);
    cycle("wrap0");
    #1;
    chk("wrap.in_ready1", int'(in_ready), 4'b0010);
    cycle("wrap1");

    in_valid = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      chk("bp.in_ready", int'(in_ready), 0);
      chk("bp.sel", int'(out_sel), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release", int'(in_ready), 4'b0100);
    cycle("bp_release");
    chk("bp.next_sel", int'(out_sel), 2);

    do_reset();
    in_valid = 4'b0100; out_ready = 1'b0;
    cycle("mid_load");
    in_valid = 4'b0000;
    cycle("mid_hold");
    chk("mid.sel_before", int'(out_sel), 2);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_outs("mid_rst");
    chk("mid.in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 4'b1000; out_ready = 1'b1;
    #1;
    chk("mid.grant3", int'(in_ready), 4'b1000);
    cycle("mid_grant");
    in_valid = 4'b0000;
    cycle("idle_clear");
    chk("idle.valid", int'(out_valid), 0);

    for (int i = 0; i < 400; i++) begin
      in_valid = 4'($urandom_range(0, 15));
      for (int c = 0; c < 4; c++) tb_d[c] = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
